// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter with a one-entry holding register.
// Define UART_TX_PARITY_EN to insert an even-parity bit before stop.
module uart_tx_buffered #(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx,
  output logic            tx_done,
  output logic            busy,
  output logic            hold_full,
  output logic            overrun
);

  localparam int SMAX =
    (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int SW =
    (SMAX > 1) ? $clog2(SMAX) : 1;
  localparam int NW =
    (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_BIT  =
    SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP =
    SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST =
    NW'(DBIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [SW-1:0]   s;
  logic [SW-1:0]   s_nxt;
  logic [NW-1:0]   n;
  logic [NW-1:0]   n_nxt;
  logic [DBIT-1:0] shreg;
  logic [DBIT-1:0] shreg_nxt;
  logic [DBIT-1:0] hold;
  logic [DBIT-1:0] hold_nxt;
  logic            hold_full_nxt;
  logic            done_nxt;
  logic            ovr_nxt;
  logic            tx_nxt;
  logic            busy_nxt;
  logic            stop_end;
`ifdef UART_TX_PARITY_EN
  logic            par;
  logic            par_nxt;
`endif

  // state, counters, data path and all outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      s         <= '0;
      n         <= '0;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      tx        <= 1'b1;
      tx_done   <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      s         <= s_nxt;
      n         <= n_nxt;
      shreg     <= shreg_nxt;
      hold      <= hold_nxt;
      hold_full <= hold_full_nxt;
      tx        <= tx_nxt;
      tx_done   <= done_nxt;
      busy      <= busy_nxt;
      overrun   <= ovr_nxt;
`ifdef UART_TX_PARITY_EN
      par       <= par_nxt;
`endif
    end
  end

  assign stop_end = (state == STOP) && tick
                 && (s == S_STOP);

  // frame sequencing plus holding-register arbitration
  always_comb begin
    state_nxt     = state;
    s_nxt         = s;
    n_nxt         = n;
    shreg_nxt     = shreg;
    hold_nxt      = hold;
    hold_full_nxt = hold_full;
    done_nxt      = 1'b0;
    ovr_nxt       = 1'b0;
    unique case (state)
      IDLE: begin
        if (tx_start) begin
          shreg_nxt = din;
          s_nxt     = '0;
          state_nxt = START;
        end
      end
      START: begin
        if (tick) begin
          if (s == S_BIT) begin
            s_nxt     = '0;
            n_nxt     = '0;
            state_nxt = DATA;
          end else begin
            s_nxt = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s == S_BIT) begin
            s_nxt     = '0;
            shreg_nxt = shreg >> 1;
            if (n == N_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_nxt = PARITY;
`else
              state_nxt = STOP;
`endif
            end else begin
              n_nxt = n + 1'b1;
            end
          end else begin
            s_nxt = s + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (s == S_BIT) begin
            s_nxt     = '0;
            state_nxt = STOP;
          end else begin
            s_nxt = s + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (s == S_STOP) begin
            done_nxt = 1'b1;
            s_nxt    = '0;
            if (hold_full) begin
              shreg_nxt     = hold;
              hold_full_nxt = 1'b0;
              state_nxt     = START;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            s_nxt = s + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // a byte offered mid-frame is parked,
    // chained, or dropped
    if (tx_start && (state != IDLE)) begin
      if (stop_end) begin
        if (hold_full) begin
          hold_nxt      = din;
          hold_full_nxt = 1'b1;
        end else begin
          shreg_nxt = din;
          s_nxt     = '0;
          state_nxt = START;
        end
      end else if (!hold_full) begin
        hold_nxt      = din;
        hold_full_nxt = 1'b1;
      end else begin
        ovr_nxt = 1'b1;
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  // parity latched whenever a byte enters shreg
  always_comb begin
    par_nxt = par;
    if (state_nxt == START) begin
      par_nxt = ^shreg_nxt;
    end
  end
`endif

  // line level and busy for the upcoming state
  always_comb begin
    tx_nxt   = 1'b1;
    busy_nxt = (state_nxt != IDLE);
    unique case (state_nxt)
      START: tx_nxt = 1'b0;
      DATA:  tx_nxt = shreg_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_nxt = par_nxt;
`endif
      default: tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered.
// Tick every 4 clks, so one bit is 64 clks.
module tb_uart_tx_buffered;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 704;
`else
  localparam int FRAME = 640;
`endif

  logic       clk;
  logic       reset;
  logic       tick;
  logic       tx_start;
  logic [7:0] din;
  logic       tx;
  logic       tx_done;
  logic       busy;
  logic       hold_full;
  logic       overrun;

  logic [1:0] tcnt = 2'd0;
  int         n_checks = 0;
  int         n_errors = 0;
  int         done_cnt = 0;
  int         ovr_cnt = 0;
  logic [7:0] rx_q[$];
  logic       rx_p_q[$];

  uart_tx_buffered #(
    .DBIT(8),
    .OVERSAMPLE(16),
    .SB_TICK(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .tx_start(tx_start),
    .din(din),
    .tx(tx),
    .tx_done(tx_done),
    .busy(busy),
    .hold_full(hold_full),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // free-running baud tick, one clk in four
  always @(posedge clk) tcnt <= tcnt + 2'd1;
  assign tick = (tcnt == 2'd3);

  // pulse counters
  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
    if (overrun === 1'b1) ovr_cnt <= ovr_cnt + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic skip(input int cnt, output bit ab);
    ab = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      @(negedge clk);
      if (reset) begin
        ab = 1'b1;
        return;
      end
    end
  endtask

  task automatic strobe(input logic [7:0] d);
    @(negedge clk);
    din = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic align;
    do @(negedge clk); while (tcnt != 2'd0);
  endtask

  task automatic wait_done(input int budget,
                           output int lat);
    lat = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (tx_done === 1'b1) begin
        lat = c;
        break;
      end
    end
    check("done_seen", 32'(lat > 0), 1);
  endtask

  function automatic logic [31:0] rx_at(int i);
    if (i < rx_q.size()) return {24'h0, rx_q[i]};
    return 32'hDEAD;
  endfunction

  // line decoder: samples mid-bit after a start edge
  initial begin : mon
    bit         ab;
    logic [7:0] b;
    logic       p;
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) begin
        b = 8'h00;
        p = 1'b0;
        skip(31, ab);
        if (!ab) begin
          check("start_bit", tx, 0);
          for (int i = 0; i < 8 && !ab; i++) begin
            skip(64, ab);
            b[i] = tx;
          end
`ifdef UART_TX_PARITY_EN
          if (!ab) skip(64, ab);
          p = tx;
`endif
          if (!ab) skip(64, ab);
          if (!ab) begin
            check("stop_bit", tx, 1);
            rx_q.push_back(b);
            rx_p_q.push_back(p);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    int lat;
    int lat1;
    int d0;
    int o0;

    reset = 1'b1;
    tx_start = 1'b0;
    din = 8'h00;
    @(negedge clk);
    din = 8'h55;
    tx_start = 1'b1;
    @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_hold", hold_full, 0);
    check("rst_done", tx_done, 0);
    check("rst_ovr", overrun, 0);
    reset = 1'b0;
    tx_start = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_tx", tx, 1);
    check("idle_busy", busy, 0);

    // single byte
    rx_q.delete();
    d0 = done_cnt;
    strobe(8'h55);
    check("t1_tx_low", tx, 0);
    check("t1_busy", busy, 1);
    wait_done(FRAME + 100, lat);
    check("t1_lat",
          32'(lat >= FRAME - 3 && lat <= FRAME), 1);
    check("t1_busy_fall", busy, 0);
    @(negedge clk);
    check("t1_done_1clk", tx_done, 0);
    check("t1_rx0", rx_at(0), 32'h55);
    check("t1_ndone", done_cnt - d0, 1);

    // back-to-back
    rx_q.delete();
    d0 = done_cnt;
    o0 = ovr_cnt;
    strobe(8'hA3);
    repeat (98) @(negedge clk);
    strobe(8'h0F);
    check("t2_hold", hold_full, 1);
    wait_done(FRAME + 100, lat);
    check("t2_nogap_busy", busy, 1);
    check("t2_nogap_tx", tx, 0);
    check("t2_hold_drain", hold_full, 0);
    wait_done(FRAME + 100, lat);
    repeat (2) @(negedge clk);
    check("t2_busy_end", busy, 0);
    check("t2_nrx", rx_q.size(), 2);
    check("t2_rx0", rx_at(0), 32'hA3);
    check("t2_rx1", rx_at(1), 32'h0F);
    check("t2_ndone", done_cnt - d0, 2);
    check("t2_novr", ovr_cnt - o0, 0);

    // overrun
    rx_q.delete();
    o0 = ovr_cnt;
    strobe(8'h11);
    repeat (98) @(negedge clk);
    strobe(8'h22);
    repeat (98) @(negedge clk);
    strobe(8'h33);
    check("t3_ovr", overrun, 1);
    check("t3_hold", hold_full, 1);
    @(negedge clk);
    check("t3_ovr_1clk", overrun, 0);
    wait_done(FRAME + 100, lat);
    wait_done(FRAME + 100, lat);
    repeat (80) @(negedge clk);
    check("t3_nrx", rx_q.size(), 2);
    check("t3_rx0", rx_at(0), 32'h11);
    check("t3_rx1", rx_at(1), 32'h22);
    check("t3_novr", ovr_cnt - o0, 1);
    check("t3_idle", busy, 0);

    // coincident strobe at stop completion
    rx_q.delete();
    o0 = ovr_cnt;
    align();
    strobe(8'h3C);
    wait_done(FRAME + 100, lat1);
    repeat (5) @(negedge clk);
    align();
    strobe(8'h3C);
    repeat (lat1 - 1) @(negedge clk);
    din = 8'h7E;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check("t4_done", tx_done, 1);
    check("t4_busy", busy, 1);
    check("t4_tx_start", tx, 0);
    check("t4_hold", hold_full, 0);
    check("t4_ovr", overrun, 0);
    wait_done(FRAME + 100, lat);
    check("t4_lat",
          32'(lat >= FRAME - 3 && lat <= FRAME), 1);
    repeat (2) @(negedge clk);
    check("t4_nrx", rx_q.size(), 3);
    check("t4_rx1", rx_at(1), 32'h3C);
    check("t4_rx2", rx_at(2), 32'h7E);
    check("t4_novr", ovr_cnt - o0, 0);

    // reset mid-frame with hold full
    rx_q.delete();
    strobe(8'hFF);
    repeat (98) @(negedge clk);
    strobe(8'hAA);
    check("t5_hold", hold_full, 1);
    repeat (190) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t5_tx", tx, 1);
    check("t5_busy", busy, 0);
    check("t5_hold_clr", hold_full, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_nrx_abort", rx_q.size(), 0);
    strobe(8'h01);
    wait_done(FRAME + 100, lat);
    repeat (2) @(negedge clk);
    check("t5_nrx", rx_q.size(), 1);
    check("t5_rx0", rx_at(0), 32'h01);
    check("t5_idle", busy, 0);

`ifdef UART_TX_PARITY_EN
    // parity bit on an odd-weight byte
    rx_q.delete();
    rx_p_q.delete();
    strobe(8'h07);
    wait_done(FRAME + 100, lat);
    check("t6_lat",
          32'(lat >= FRAME - 3 && lat <= FRAME), 1);
    repeat (2) @(negedge clk);
    check("t6_rx0", rx_at(0), 32'h07);
    check("t6_par", 32'(rx_p_q.size() == 1
          && rx_p_q[0] == 1'b1), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
